uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that turns an asynchronous 8N1 UART line into one byte per frame, using 16× oversampling with a majority vote. It sits directly upstream of the byte-processing stage that collects and echoes frames. It drives that stage's `rxReady`/`rxData` inputs with a single-cycle valid strobe per accepted byte. Malformed frames are flagged on a separate error strobe and never presented as data.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate.
- `OVERSAMPLE`, default 16: sample ticks per bit. Fixed at 16; other values are unsupported.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line, idle high.
- `rxReady` output 1: one-cycle strobe, `rxData` valid.
- `rxData` output 8: last accepted byte; holds until next accepted frame.
- `rxErr` output 1: one-cycle strobe on framing (or parity) error.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxS`.
- Tick generator: divider `DIV = (CLK_HZ + BAUD*8) / (BAUD*16)`, rounded to nearest, with a minimum of 1. It emits a 1-clk `tick` every `DIV` clocks.
- A 4-bit `tickCnt` (0..15) indexes position within a bit.
- States:
  - `IDLE` → `START`: on a high-to-low transition of `rxS`. The divider and `tickCnt` clear to 0 on that clock.
  - `START`: at tick 9, evaluate the majority of samples taken at ticks 7, 8 and 9.
    - Majority high: false start, return to `IDLE`. No strobes.
    - Majority low: at tick 15 go to `DATA`, with bit index 0.
  - `DATA`: majority of ticks 7/8/9 is shifted into `shiftReg`, LSB first. At tick 15:
    - If bit index is 7: go to `PARITY` (macro set) or `STOP` (macro unset).
    - Otherwise: increment the bit index.
  - `PARITY`: majority of ticks 7/8/9 is compared against even parity of `shiftReg`. At tick 15, go to `STOP` and carry a `parityBad` flag.
  - `STOP`: majority decided at tick 9.
    - Stop bit high and no parity error: `rxData <= shiftReg`, pulse `rxReady`, go to `IDLE`.
    - Otherwise: pulse `rxErr`, leave `rxData` unchanged, go to `WAITHI`.
  - `WAITHI`: stay until `rxS` = 1, then go to `IDLE`.
- `rxReady` and `rxErr` are never asserted in the same cycle, and never for more than 1 clock.
- Reset values: `rxReady`=0, `rxErr`=0, `rxData`=8'h00, state `IDLE`, `shiftReg`=0, both counters 0.
- `rst` mid-frame aborts the frame, with no strobe. A line still low after reset is ignored until `rxS` rises and then falls again.

## Timing
- The synchronizer adds 2 clk of latency from `rx` to `rxS`.
- `rxReady` and `rxErr` are registered. They assert 1 clk after the tick-9 sample of the stop bit, which is about 9.56 bit times after the start edge at `rxS`.
- Returning to `IDLE` at mid-stop lets a back-to-back frame's start edge, arriving half a bit later, be detected with no gap required.
- Baud tolerance is ±3% cumulative at `OVERSAMPLE` = 16.
- The downstream stage samples `rxReady` every clock. The one-cycle strobe guarantees exactly one capture per byte, and no flow control is provided. A new byte overwrites `rxData` regardless of whether it was consumed.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1: start, 8 data, even parity, stop.
  - A parity mismatch yields `rxErr` instead of `rxReady`, and `rxData` is not updated.
- Undefined:
  - Frame is 8N1 and the `PARITY` state is not built.
  - `rxErr` reports stop-bit errors only.

## Test plan
Parameters: `CLK_HZ`=1_600_000 and `BAUD`=10_000, giving `DIV`=10 and 160 clk/bit.
- Reset and idle: hold `rst`=1 for 3 clk with `rx`=1, then run 1000 clk → `rxReady`=0, `rxErr`=0 and `rxData`=8'h00 throughout.
- Single frame 8'hA5, 8N1 → exactly one `rxReady` pulse, 1 clk wide, about 1530 clk after the start edge; `rxData`=8'hA5; `rxErr` never high.
- Glitch: `rx` low for 40 clk, then high → no `rxReady`, no `rxErr`; a following frame 8'h3C is received correctly.
- Framing error: 8'h3C sent with stop bit 0, then the line held low for 300 clk → one `rxErr` pulse and `rxData` stays 8'hA5; after `rx` rises, frame 8'h5A gives `rxReady` with `rxData`=8'h5A.
- Back-to-back: 8'h01, 8'h02, 8'h03 with zero idle time → three `rxReady` pulses carrying 01, 02, 03 in order. Then assert `rst` for 1 clk in the middle of the data bits of a fourth frame → no strobe, and the next clean frame is received.
- Parity (`UART_RX_PARITY_EN`): 8'h07 with parity bit 1 → `rxReady` with `rxData`=8'h07; 8'h07 with parity bit 0 → `rxErr` only, `rxData` unchanged.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1 by default, 16x oversampling with a
// 3-sample majority vote around mid-bit. Define UART_RX_PARITY_EN to receive 8E1
// frames (even parity checked before the stop bit).
`default_nettype none

module uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       rxErr
);

  // Round-to-nearest oversample divider, never below 1.
  localparam int DIV_CALC = (CLK_HZ + BAUD * (OVERSAMPLE / 2)) / (BAUD * OVERSAMPLE);
  localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
  localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
`endif

  state_t        state;
  state_t        stateNext;
  logic          rxMeta;
  logic          rxS;
  logic [1:0]    syncValid;
  logic          rxPrev;
  logic [DW-1:0] divCnt;
  logic [3:0]    tickCnt;
  logic [2:0]    bitIdx;
  logic          s7;
  logic          s8;
  logic [7:0]    shiftReg;
  logic          readyNext;
  logic          errNext;
`ifdef UART_RX_PARITY_EN
  logic          parityBad;
`endif

  logic tick;
  logic sample9;
  logic sample15;
  logic maj;
  logic fallEdge;

  assign tick     = (divCnt == DIV_LAST);
  assign sample9  = tick && (tickCnt == 4'd9);
  assign sample15 = tick && (tickCnt == 4'd15);
  assign maj      = (s7 & s8) | (s7 & rxS) | (s8 & rxS);
  assign fallEdge = rxPrev & ~rxS;

  // Two-flop synchronizer; rxPrev only goes high once rxS carries a real line
  // value, so a line already low when reset ends cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta    <= 1'b1;
      rxS       <= 1'b1;
      syncValid <= 2'b00;
      rxPrev    <= 1'b0;
    end else begin
      rxMeta    <= rx;
      rxS       <= rxMeta;
      syncValid <= {syncValid[0], 1'b1};
      rxPrev    <= syncValid[1] & rxS;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and strobe decisions, all taken on sample ticks of the current bit.
  always_comb begin
    stateNext = state;
    readyNext = 1'b0;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (fallEdge) stateNext = START;
      end
      START: begin
        if (sample9 && maj) stateNext = IDLE;
        else if (sample15)  stateNext = DATA;
      end
      DATA: begin
        if (sample15 && (bitIdx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          stateNext = PARITY;
`else
          stateNext = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample15) stateNext = STOP;
      end
`endif
      STOP: begin
        if (sample9) begin
`ifdef UART_RX_PARITY_EN
          if (maj && !parityBad) begin
`else
          if (maj) begin
`endif
            stateNext = IDLE;
            readyNext = 1'b1;
          end else begin
            stateNext = WAITHI;
            errNext   = 1'b1;
          end
        end
      end
      WAITHI: begin
        if (rxS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bit timing, sampling, shifting and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt    <= '0;
      tickCnt   <= 4'd0;
      bitIdx    <= 3'd0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      shiftReg  <= 8'h00;
      rxReady   <= 1'b0;
      rxErr     <= 1'b0;
      rxData    <= 8'h00;
`ifdef UART_RX_PARITY_EN
      parityBad <= 1'b0;
`endif
    end else begin
      rxReady <= readyNext;
      rxErr   <= errNext;
      if (readyNext) rxData <= shiftReg;
      if (state == IDLE) begin
        divCnt    <= '0;
        tickCnt   <= 4'd0;
        bitIdx    <= 3'd0;
`ifdef UART_RX_PARITY_EN
        parityBad <= 1'b0;
`endif
      end else begin
        divCnt <= tick ? '0 : divCnt + 1'b1;
        if (tick) tickCnt <= tickCnt + 4'd1;
        if (tick && (tickCnt == 4'd7)) s7 <= rxS;
        if (tick && (tickCnt == 4'd8)) s8 <= rxS;
        if ((state == DATA) && sample9)  shiftReg <= {maj, shiftReg[7:1]};
        if ((state == DATA) && sample15) bitIdx <= bitIdx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if ((state == PARITY) && sample9) parityBad <= (maj != (^shiftReg));
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives whole UART frames at 160 clk/bit and checks the received
// strobes and data against a frame-level model (a frame is accepted exactly
// when its stop bit is high and, with UART_RX_PARITY_EN, its parity is even).
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    bit         stopBit;
    bit         parityOk;
    int         lowHold;
    int         idleAfter;
    bit         expErr;
    logic [7:0] expRxData;
  } FrameVec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rxReady;
  logic       rxErr;
  logic [7:0] rxData;

  int         compared   = 0;
  int         mismatched = 0;
  int         cycle      = 0;
  int         fallCycle  = 0;
  int         readyCycle = 0;
  logic       prevStrobe = 1'b0;
  logic [8:0] gotQ[$];
  logic [7:0] modelData  = 8'h00;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rxReady (rxReady),
    .rxData  (rxData),
    .rxErr   (rxErr)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Record every strobe and check strobes are exclusive and one clock wide.
  always @(negedge clk) begin
    if (rxReady === 1'b1 || rxErr === 1'b1) begin
      checkOutput("strobe exclusive", 32'(rxReady & rxErr), 32'd0);
      checkOutput("strobe width", 32'(prevStrobe), 32'd0);
      if (rxReady === 1'b1) begin
        gotQ.push_back({1'b0, rxData});
        readyCycle = cycle;
      end else begin
        gotQ.push_back({1'b1, rxData});
      end
    end
    prevStrobe = (rxReady === 1'b1) || (rxErr === 1'b1);
  end

  // Drive one frame; rstAt >= 0 pulses rst for one clock at that clock of the frame.
  task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input bit parityOk,
                               input int lowHold, input int idleAfter, input int rstAt);
    logic [10:0] bits;
    int k;
    bits      = '0;
    bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
    bits[9]   = parityOk ? (^data) : ~(^data);
    bits[10]  = stopBit;
`else
    bits[9]   = stopBit;
`endif
    k = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(negedge clk);
        if (k == 0) fallCycle = cycle;
        rx  = bits[b];
        rst = (k == rstAt);
        k++;
      end
    end
    for (int c = 0; c < lowHold; c++) begin
      @(negedge clk);
      rx  = 1'b0;
      rst = 1'b0;
    end
    for (int c = 0; c < idleAfter; c++) begin
      @(negedge clk);
      rx  = 1'b1;
      rst = 1'b0;
    end
  endtask

  // Expect exactly one strobe since the last check, then check rxData holds the model value.
  task automatic expectEvent(input string name, input bit expErr, input logic [7:0] expData);
    logic [8:0] ev;
    checkOutput({name, " count"}, 32'(gotQ.size()), 32'd1);
    if (gotQ.size() > 0) begin
      ev = gotQ.pop_front();
      checkOutput({name, " kind"}, 32'(ev[8]), 32'(expErr));
      if (!expErr) checkOutput({name, " data"}, 32'(ev[7:0]), 32'(expData));
    end
    gotQ.delete();
    checkOutput({name, " rxData"}, 32'(rxData), 32'(modelData));
  endtask

  // Overall time limit so the bench can never hang.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    FrameVec vecs[$];
    int bad;
    int lat;
    int stopStart;
    logic [7:0] d;
    bit stop, pOk, valid;
    int hold, idle;

    // Reset and idle behaviour.
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset rxReady", 32'(rxReady), 32'd0);
    checkOutput("reset rxErr", 32'(rxErr), 32'd0);
    checkOutput("reset rxData", 32'(rxData), 32'h00);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rxReady !== 1'b0 || rxErr !== 1'b0 || rxData !== 8'h00) bad++;
    end
    checkOutput("idle quiet cycles", 32'(bad), 32'd0);
    checkOutput("idle no events", 32'(gotQ.size()), 32'd0);

    // Directed frame table.
    vecs.push_back('{8'hA5, 1'b1, 1'b1, 0,   320, 1'b0, 8'hA5});
    vecs.push_back('{8'h3C, 1'b0, 1'b1, 300, 320, 1'b1, 8'hA5});
    vecs.push_back('{8'h5A, 1'b1, 1'b1, 0,   320, 1'b0, 8'h5A});
    vecs.push_back('{8'h01, 1'b1, 1'b1, 0,   0,   1'b0, 8'h01});
    vecs.push_back('{8'h02, 1'b1, 1'b1, 0,   0,   1'b0, 8'h02});
    vecs.push_back('{8'h03, 1'b1, 1'b1, 0,   320, 1'b0, 8'h03});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 0,   320, 1'b0, 8'h07});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 0,   320, 1'b1, 8'h07});
`endif
    stopStart = (FRAME_BITS - 1) * BIT_CLKS;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].data, vecs[i].stopBit, vecs[i].parityOk,
                    vecs[i].lowHold, vecs[i].idleAfter, -1);
      modelData = vecs[i].expRxData;
      expectEvent($sformatf("vec%0d", i), vecs[i].expErr, vecs[i].expRxData);
      if (i == 0) begin
        lat = readyCycle - fallCycle;
        checkOutput("first frame latency in window", 32'(lat >= stopStart + 80 && lat <= stopStart + 120), 32'd1);
      end
    end

    // Short low glitch must be rejected, then a normal frame still received.
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    checkOutput("glitch no events", 32'(gotQ.size()), 32'd0);
    applyStimulus(8'h3C, 1'b1, 1'b1, 0, 320, -1);
    modelData = 8'h3C;
    expectEvent("after glitch", 1'b0, 8'h3C);

    // Reset in the middle of the data bits: no strobe, rxData back to 0.
    applyStimulus(8'h00, 1'b1, 1'b1, 0, 320, 4 * BIT_CLKS + 50);
    modelData = 8'h00;
    checkOutput("midreset no events", 32'(gotQ.size()), 32'd0);
    checkOutput("midreset rxData", 32'(rxData), 32'h00);
    applyStimulus(8'hC3, 1'b1, 1'b1, 0, 320, -1);
    modelData = 8'hC3;
    expectEvent("after midreset", 1'b0, 8'hC3);

    // Random frames against the frame-level acceptance rule.
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      pOk  = ($urandom_range(0, 4) != 0);
      hold = stop ? 0 : int'($urandom_range(0, 200));
      idle = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(10, 200));
      if (!stop && idle < 10) idle = 10;
      valid = stop;
`ifdef UART_RX_PARITY_EN
      valid = valid && pOk;
`endif
      applyStimulus(d, stop, pOk, hold, idle, -1);
      if (valid) modelData = d;
      expectEvent($sformatf("rand%0d", i), !valid, d);
    end

    repeat (200) @(negedge clk);
    checkOutput("final no stray events", 32'(gotQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
